// File: rtl/half_adder_pkg.sv
// Shared constants and helpers for the half_adder_core block.
// Holds the default lane count, the default carry-event counter width
// and the saturating increment used by the optional statistics counter.
package half_adder_pkg;

  localparam int unsigned DEFAULT_WIDTH = 1;
  localparam int unsigned DEFAULT_CNT_W = 16;

  // Adds one to value unless it has already reached max. Works on a
  // 64-bit container so that any counter width up to 64 can use it.
  function automatic logic [63:0] sat_inc(input logic [63:0] value,
                                          input logic [63:0] max);
    sat_inc = (value >= max) ? value : value + 64'd1;
  endfunction

endpackage

// File: rtl/half_adder_bit.sv
// One-bit combinational half adder: sum is a XOR b, carry is a AND b.
// Used once per lane by half_adder_core; it holds no state.
module half_adder_bit (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b;
  assign carry = a & b;

endmodule

// File: rtl/half_adder_core.sv
// Clocked, vectorised half adder. Each lane is independent (no carry
// ripple between lanes); results appear one cycle after an accepted input
// and are flagged by out_valid. Every output comes straight from a flop.
// Optional feature macro: HALF_ADDER_STATS_EN adds the carry_cnt port and a
// saturating counter of accepted cycles whose carry_any is 1.
module half_adder_core
  import half_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] carry,
  output logic             carry_any
`ifdef HALF_ADDER_STATS_EN
  ,
  output logic [CNT_W-1:0] carry_cnt
`endif
);

  logic [WIDTH-1:0] sum_d;
  logic [WIDTH-1:0] carry_d;
  logic             carry_any_d;

  // Illegal widths leave an empty, named marker block in the elaborated
  // hierarchy; legal widths produce nothing here.
  if (WIDTH < 1 || WIDTH > 64 || CNT_W < 1 || CNT_W > 64) begin : g_bad_config
  end

  // One combinational half adder per lane.
  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    half_adder_bit u_bit (
      .a     (a[i]),
      .b     (b[i]),
      .sum   (sum_d[i]),
      .carry (carry_d[i])
    );
  end

  assign carry_any_d = |carry_d;

  // The valid flag follows in_valid with one cycle of delay, so every accepted
  // input yields exactly one out_valid pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
    end
  end

  // Result registers load only on accepted cycles and otherwise keep the
  // last result visible.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum       <= '0;
      carry     <= '0;
      carry_any <= 1'b0;
    end else if (in_valid) begin
      sum       <= sum_d;
      carry     <= carry_d;
      carry_any <= carry_any_d;
    end
  end

`ifdef HALF_ADDER_STATS_EN
  localparam logic [63:0] CntMax = 64'({CNT_W{1'b1}});

  // Count accepted cycles that produce a carry in any lane, stopping at the
  // all-ones value instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      carry_cnt <= '0;
    end else if (in_valid && carry_any_d) begin
      carry_cnt <= CNT_W'(sat_inc(64'(carry_cnt), CntMax));
    end
  end
`else
  // Statistics build option is off: no counter and no carry_cnt port.
`endif

endmodule

// File: tb/tb_half_adder_core.sv
// Self-checking bench for half_adder_core. Two instances run in lockstep
// on shared clock, reset and in_valid: a WIDTH=1 instance and a WIDTH=8
// instance, both with a 4-bit carry counter when HALF_ADDER_STATS_EN is set.
// Expected results are pushed to a scoreboard queue when inputs are driven
// and popped once the capturing edge has passed.
module tb_half_adder_core;

  typedef struct packed {
    logic       v1;
    logic       s1;
    logic       c1;
    logic       any1;
    logic       v8;
    logic [7:0] s8;
    logic [7:0] c8;
    logic       any8;
  } out_t;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       a1;
  logic       b1;
  logic [7:0] a8;
  logic [7:0] b8;

  logic       out_valid1;
  logic       sum1;
  logic       carry1;
  logic       carry_any1;
  logic       out_valid8;
  logic [7:0] sum8;
  logic [7:0] carry8;
  logic       carry_any8;
`ifdef HALF_ADDER_STATS_EN
  logic [3:0] carry_cnt1;
  logic [3:0] carry_cnt8;
`endif

  int   errors = 0;
  int   checks = 0;
  out_t sbq[$];
  out_t m;
  int   cnt1;
  int   cnt8;

  half_adder_core #(.WIDTH(1), .CNT_W(4)) u_dut1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a1),
    .b         (b1),
    .out_valid (out_valid1),
    .sum       (sum1),
    .carry     (carry1),
    .carry_any (carry_any1)
`ifdef HALF_ADDER_STATS_EN
    ,
    .carry_cnt (carry_cnt1)
`endif
  );

  half_adder_core #(.WIDTH(8), .CNT_W(4)) u_dut8 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a8),
    .b         (b8),
    .out_valid (out_valid8),
    .sum       (sum8),
    .carry     (carry8),
    .carry_any (carry_any8)
`ifdef HALF_ADDER_STATS_EN
    ,
    .carry_cnt (carry_cnt8)
`endif
  );

  // Free-running 10-time-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference half adder worked out from operand values alone.
  function automatic out_t model(input logic ai1, input logic bi1,
                                 input logic [7:0] ai8, input logic [7:0] bi8);
    out_t r;
    r.v1   = 1'b1;
    r.s1   = ai1 ^ bi1;
    r.c1   = ai1 & bi1;
    r.any1 = ai1 & bi1;
    r.v8   = 1'b1;
    r.s8   = ai8 ^ bi8;
    r.c8   = ai8 & bi8;
    r.any8 = |(ai8 & bi8);
    return r;
  endfunction

  function automatic out_t observed();
    out_t r;
    r = '{v1: out_valid1, s1: sum1, c1: carry1, any1: carry_any1,
          v8: out_valid8, s8: sum8, c8: carry8, any8: carry_any8};
    return r;
  endfunction

  // Drive one cycle of inputs, queue the expected result if the input is
  // accepted, cross the edge and retire the scoreboard entry into the model.
  task automatic applyStimulus(input logic v, input logic ai1, input logic bi1,
                               input logic [7:0] ai8, input logic [7:0] bi8);
    out_t e;
    in_valid = v;
    a1 = ai1;
    b1 = bi1;
    a8 = ai8;
    b8 = bi8;
    if (v && !rst) sbq.push_back(model(ai1, bi1, ai8, bi8));
    @(posedge clk);
    #1;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      m = e;
      if (e.any1 && cnt1 < 15) cnt1++;
      if (e.any8 && cnt8 < 15) cnt8++;
    end else begin
      m.v1 = 1'b0;
      m.v8 = 1'b0;
    end
  endtask

  task automatic modelReset();
    sbq.delete();
    m    = '0;
    cnt1 = 0;
    cnt8 = 0;
  endtask

  task automatic test_reset();
    rst      = 1'b1;
    in_valid = 1'b1;
    a1 = 1'b1;
    b1 = 1'b1;
    a8 = 8'hFF;
    b8 = 8'hFF;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (observed() !== out_t'(0)) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got %h expected %h", observed(), out_t'(0));
    end
`ifdef HALF_ADDER_STATS_EN
    checks++;
    if (carry_cnt1 !== 4'd0 || carry_cnt8 !== 4'd0) begin
      errors++;
      $display("[TB] FAIL reset_cnt: got %0d/%0d expected 0/0", carry_cnt1, carry_cnt8);
    end
`endif
    in_valid = 1'b0;
    a1 = 1'b0;
    b1 = 1'b0;
    a8 = 8'h00;
    b8 = 8'h00;
    rst = 1'b0;
  endtask

  task automatic test_truth_table();
    logic [1:0] pat;
    for (int i = 0; i < 4; i++) begin
      pat = 2'(i);
      applyStimulus(1'b1, pat[1], pat[0], {8{pat[1]}}, {8{pat[0]}});
      checks++;
      if (observed() !== m) begin
        errors++;
        $display("[TB] FAIL truth_table[%0d]: got %h expected %h", i, observed(), m);
      end
    end
    checks++;
    if (sum1 !== 1'b0 || carry1 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL truth_table_last: got sum=%b carry=%b expected sum=0 carry=1", sum1, carry1);
    end
`ifdef HALF_ADDER_STATS_EN
    checks++;
    if (carry_cnt1 !== 4'd1 || carry_cnt8 !== 4'd1) begin
      errors++;
      $display("[TB] FAIL truth_table_cnt: got %0d/%0d expected 1/1", carry_cnt1, carry_cnt8);
    end
`endif
  endtask

  task automatic test_width8();
    applyStimulus(1'b1, 1'b0, 1'b1, 8'hF0, 8'hCC);
    checks++;
    if (sum8 !== 8'h3C || carry8 !== 8'hC0 || carry_any8 !== 1'b1 || out_valid8 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL width8: got sum=%h carry=%h any=%b valid=%b expected 3c c0 1 1",
               sum8, carry8, carry_any8, out_valid8);
    end
    checks++;
    if (observed() !== m) begin
      errors++;
      $display("[TB] FAIL width8_all: got %h expected %h", observed(), m);
    end
  endtask

  task automatic test_hold();
    applyStimulus(1'b1, 1'b1, 1'b1, 8'h81, 8'hFF);
    checks++;
    if (observed() !== m || out_valid1 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL hold_load: got %h expected %h", observed(), m);
    end
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      checks++;
      if (observed() !== m || out_valid1 !== 1'b0 || carry1 !== 1'b1 || sum1 !== 1'b0) begin
        errors++;
        $display("[TB] FAIL hold[%0d]: got %h expected %h", i, observed(), m);
      end
    end
  endtask

  task automatic test_no_carry();
    int before1;
    int before8;
    before1 = cnt1;
    before8 = cnt8;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 8'h5A, 8'h00);
      checks++;
      if (observed() !== m || carry_any1 !== 1'b0 || sum1 !== 1'b1) begin
        errors++;
        $display("[TB] FAIL no_carry[%0d]: got %h expected %h", i, observed(), m);
      end
    end
`ifdef HALF_ADDER_STATS_EN
    checks++;
    if (int'(carry_cnt1) != before1 || int'(carry_cnt8) != before8) begin
      errors++;
      $display("[TB] FAIL no_carry_cnt: got %0d/%0d expected %0d/%0d",
               carry_cnt1, carry_cnt8, before1, before8);
    end
`endif
  endtask

  task automatic test_back_to_back();
    logic [7:0] ra;
    logic [7:0] rb;
    for (int i = 0; i < 12; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      applyStimulus(1'b1, ra[0], rb[0], ra, rb);
      checks++;
      if (observed() !== m) begin
        errors++;
        $display("[TB] FAIL back_to_back[%0d]: got %h expected %h", i, observed(), m);
      end
    end
`ifdef HALF_ADDER_STATS_EN
    checks++;
    if (int'(carry_cnt1) != cnt1 || int'(carry_cnt8) != cnt8) begin
      errors++;
      $display("[TB] FAIL back_to_back_cnt: got %0d/%0d expected %0d/%0d",
               carry_cnt1, carry_cnt8, cnt1, cnt8);
    end
`endif
  endtask

  task automatic test_midstream_reset();
    applyStimulus(1'b1, 1'b1, 1'b1, 8'hFF, 8'h0F);
    checks++;
    if (out_valid1 !== 1'b1 || carry1 !== 1'b1 || observed() !== m) begin
      errors++;
      $display("[TB] FAIL midreset_pre: got %h expected %h", observed(), m);
    end
    #3;
    rst = 1'b1;
    modelReset();
    #1;
    checks++;
    if (observed() !== out_t'(0)) begin
      errors++;
      $display("[TB] FAIL midreset_async: got %h expected %h", observed(), out_t'(0));
    end
`ifdef HALF_ADDER_STATS_EN
    checks++;
    if (carry_cnt1 !== 4'd0 || carry_cnt8 !== 4'd0) begin
      errors++;
      $display("[TB] FAIL midreset_cnt: got %0d/%0d expected 0/0", carry_cnt1, carry_cnt8);
    end
`endif
    #2;
    rst = 1'b0;
    applyStimulus(1'b1, 1'b1, 1'b0, 8'hA5, 8'h0F);
    checks++;
    if (observed() !== m || sum8 !== 8'hAA || carry8 !== 8'h05) begin
      errors++;
      $display("[TB] FAIL midreset_post: got %h expected %h", observed(), m);
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b1, 8'hFF, 8'hFF);
      checks++;
      if (observed() !== m) begin
        errors++;
        $display("[TB] FAIL saturation[%0d]: got %h expected %h", i, observed(), m);
      end
    end
`ifdef HALF_ADDER_STATS_EN
    checks++;
    if (carry_cnt1 !== 4'd15 || carry_cnt8 !== 4'd15) begin
      errors++;
      $display("[TB] FAIL saturation_cnt: got %0d/%0d expected 15/15", carry_cnt1, carry_cnt8);
    end
`endif
  endtask

  // Run every scenario in order, then report.
  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    a1 = 1'b0;
    b1 = 1'b0;
    a8 = 8'h00;
    b8 = 8'h00;
    m    = '0;
    cnt1 = 0;
    cnt8 = 0;
    test_reset();
    test_truth_table();
    test_width8();
    test_hold();
    test_no_carry();
    test_back_to_back();
    test_midstream_reset();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
